// File: rtl/booth_multiplier_1.sv
// Sequential radix-2 Booth multiplier for signed two's-complement operands.
// One Booth step per clock; busy is high for exactly WIDTH cycles after an
// accepted start, and product updates on the edge where busy falls.
// Optional feature macro: BOOTH_DONE_PULSE_EN adds a one-cycle done pulse
// on completion. Without it, completion is signalled by busy falling.
//
// Handshake: start is sampled on every rising edge. It is accepted only
// while idle (busy=0), and the operands are captured on that same edge.
// start while busy is dropped, not queued. product is valid whenever busy
// is low, and it holds the previous result until the next completion.
module booth_multiplier_1 #(
  parameter int WIDTH = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               debug_state,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
`ifdef BOOTH_DONE_PULSE_EN
  ,
  output logic               done
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] m_reg;
  // The accumulator is one bit wider than the operands so that negating
  // the most-negative multiplicand cannot overflow.
  logic [WIDTH:0]   a_reg;
  logic [WIDTH-1:0] q_reg;
  logic             q_1;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   a_next;
  logic [WIDTH-1:0] q_next;
  logic             q1_next;

  // Expose the FSM state: 1 while running, 0 while idle.
  assign debug_state = (state == RUN);

  // Single Booth step: add, subtract or skip, then arithmetic shift right.
  always_comb begin
    m_ext = {m_reg[WIDTH-1], m_reg};
    sum   = a_reg;
    case ({q_reg[0], q_1})
      2'b01:   sum = a_reg + m_ext;
      2'b10:   sum = a_reg - m_ext;
      default: sum = a_reg;
    endcase
    a_next  = {sum[WIDTH], sum[WIDTH:1]};
    q_next  = {sum[0], q_reg[WIDTH-1:1]};
    q1_next = q_reg[0];
  end

  // Control FSM and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      m_reg   <= '0;
      a_reg   <= '0;
      q_reg   <= '0;
      q_1     <= 1'b0;
      count   <= '0;
      product <= '0;
      busy    <= 1'b0;
`ifdef BOOTH_DONE_PULSE_EN
      done    <= 1'b0;
`endif
    end else begin
`ifdef BOOTH_DONE_PULSE_EN
      done <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            m_reg <= multiplicand;
            q_reg <= multiplier;
            a_reg <= '0;
            q_1   <= 1'b0;
            count <= CW'(WIDTH);
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_reg <= a_next;
          q_reg <= q_next;
          q_1   <= q1_next;
          count <= count - CW'(1);
          // The last step: the shifted result is already final.
          if (count == CW'(1)) begin
            product <= {a_next[WIDTH-1:0], q_next};
            busy    <= 1'b0;
            state   <= IDLE;
`ifdef BOOTH_DONE_PULSE_EN
            done    <= 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_multiplier_1.sv
// Testbench for booth_multiplier_1 (WIDTH=4): a table of directed vectors
// plus hand-written sequences for reset, ignored start and back-to-back use.
module tb_booth_multiplier_1;

  localparam int W = 4;

  logic           clock;
  logic           reset_n;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           debug_state;
  logic [2*W-1:0] product;
  logic           busy;
`ifdef BOOTH_DONE_PULSE_EN
  logic           done;
`endif

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] model_prod;

  typedef struct {
    logic [W-1:0]   m;
    logic [W-1:0]   q;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs[12];

  booth_multiplier_1 #(.WIDTH(W)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .debug_state  (debug_state),
    .product      (product),
    .busy         (busy)
`ifdef BOOTH_DONE_PULSE_EN
    ,
    .done         (done)
`endif
  );

  // Clock and global time limit.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Wait on negedges until busy falls; returns the number of edges waited.
  task automatic wait_busy_low(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  // Single operation: pulse start for one edge, scramble operands afterwards,
  // check latency, product hold during the run and the final product.
  task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q,
                        input logic [2*W-1:0] exp, input string name);
    int cyc;
    logic [2*W-1:0] want;
    exp_q.push_back(exp);
    @(negedge clock);
    start = 1'b1;
    multiplicand = m;
    multiplier = q;
    @(negedge clock);
    start = 1'b0;
    multiplicand = ~m;
    multiplier = ~q;
    check({name, "_busy_rise"}, 32'(busy), 32'd1);
    check({name, "_state_run"}, 32'(debug_state), 32'd1);
    check({name, "_prod_hold"}, 32'(product), 32'(model_prod));
`ifdef BOOTH_DONE_PULSE_EN
    check({name, "_done_low"}, 32'(done), 32'd0);
`endif
    wait_busy_low(cyc);
    check({name, "_busy_len"}, 32'(cyc), 32'(W));
    want = exp_q.pop_front();
    check({name, "_prod"}, 32'(product), 32'(want));
    model_prod = want;
`ifdef BOOTH_DONE_PULSE_EN
    check({name, "_done_pulse"}, 32'(done), 32'd1);
    @(negedge clock);
    check({name, "_done_single"}, 32'(done), 32'd0);
`endif
  endtask

  initial begin
    int cyc;
    vecs[0]  = '{4'b1100, 4'b1011, 8'h14};  // -4 * -5 = 20
    vecs[1]  = '{4'b1000, 4'b1000, 8'h40};  // -8 * -8 = 64
    vecs[2]  = '{4'b0111, 4'b1000, 8'hC8};  //  7 * -8 = -56
    vecs[3]  = '{4'b0000, 4'b0101, 8'h00};  //  0 *  5 = 0
    vecs[4]  = '{4'b0011, 4'b0010, 8'h06};  //  3 *  2 = 6
    vecs[5]  = '{4'b1101, 4'b0010, 8'hFA};  // -3 *  2 = -6
    vecs[6]  = '{4'b0111, 4'b0111, 8'h31};  //  7 *  7 = 49
    vecs[7]  = '{4'b1000, 4'b0111, 8'hC8};  // -8 *  7 = -56
    vecs[8]  = '{4'b1111, 4'b1111, 8'h01};  // -1 * -1 = 1
    vecs[9]  = '{4'b1000, 4'b0001, 8'hF8};  // -8 *  1 = -8
    vecs[10] = '{4'b0101, 4'b1101, 8'hF1};  //  5 * -3 = -15
    vecs[11] = '{4'b1111, 4'b0111, 8'hF9};  // -1 *  7 = -7

    // Reset state.
    reset_n = 1'b0;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    model_prod = '0;
    @(negedge clock);
    @(negedge clock);
    check("reset_product", 32'(product), 32'h0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_state", 32'(debug_state), 32'd0);
`ifdef BOOTH_DONE_PULSE_EN
    check("reset_done", 32'(done), 32'd0);
`endif
    reset_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 12; i++)
      run_op(vecs[i].m, vecs[i].q, vecs[i].exp, $sformatf("v%0d", i));

    // Asynchronous reset between clock edges clears a nonzero product.
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_product", 32'(product), 32'h0);
    check("async_reset_busy", 32'(busy), 32'd0);
    model_prod = '0;
    @(negedge clock);
    reset_n = 1'b1;

    // A start pulse with new operands during busy is ignored.
    run_op(4'b0101, 4'b0101, 8'h19, "pre_ign");  // 5*5 = 25
    @(negedge clock);
    start = 1'b1;
    multiplicand = 4'b1101;
    multiplier = 4'b0010;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    start = 1'b1;
    multiplicand = 4'b0111;
    multiplier = 4'b0111;
    @(negedge clock);
    start = 1'b0;
    wait_busy_low(cyc);
    check("ign_busy_len", 32'(cyc + 2), 32'(W));
    check("ign_prod", 32'(product), 32'hFA);
    @(negedge clock);
    check("ign_not_queued", 32'(busy), 32'd0);
    check("ign_prod_stable", 32'(product), 32'hFA);
    model_prod = 8'hFA;

    // Reset during the run aborts it; a new operation then works.
    @(negedge clock);
    start = 1'b1;
    multiplicand = 4'b0111;
    multiplier = 4'b0111;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_product", 32'(product), 32'h0);
    model_prod = '0;
    @(negedge clock);
    check("abort_held_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    run_op(4'b0011, 4'b0010, 8'h06, "post_abort");

    // start held high: one idle edge between back-to-back operations.
    @(negedge clock);
    start = 1'b1;
    multiplicand = 4'b1100;
    multiplier = 4'b1011;
    @(negedge clock);
    check("b2b_busy1", 32'(busy), 32'd1);
    wait_busy_low(cyc);
    check("b2b_len1", 32'(cyc), 32'(W));
    check("b2b_prod1", 32'(product), 32'h14);
    multiplicand = 4'b0011;
    multiplier = 4'b0010;
    @(negedge clock);
    check("b2b_busy2", 32'(busy), 32'd1);
    check("b2b_hold", 32'(product), 32'h14);
    start = 1'b0;
    wait_busy_low(cyc);
    check("b2b_len2", 32'(cyc), 32'(W));
    check("b2b_prod2", 32'(product), 32'h06);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
